// File: rtl/pll_lock_seq_if.sv
// Signal bundle between the PLL lock sequencer and its PLL / software / downstream side.
// The slave modport is the sequencer; the master modport is whatever drives lock and relock.
interface pll_lock_seq_if;
    logic       pll_lock;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    modport master (
        output pll_lock,
        output relock_req,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  fail,
        input  retry_cnt,
        input  lock_loss_cnt
    );

    modport slave (
        input  pll_lock,
        input  relock_req,
        output pll_rst,
        output sys_rst,
        output ready,
        output fail,
        output retry_cnt,
        output lock_loss_cnt
    );
endinterface

// File: rtl/pll_lock_seq.sv
// PLL reset/lock sequencer: holds the PLL in reset, qualifies lock, retries on timeout, relocks.
// Define PLL_LOCK_LOSS_CNT_EN to build the saturating lock-loss event counter.
module pll_lock_seq #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRY           = 3,
    parameter int CNT_W               = 17
) (
    input  logic          clk,
    input  logic          rst,
    pll_lock_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_HOLD      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRY);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             lock_meta_q, lock_meta_d;
    logic             lock_s_q, lock_s_d;

    // pll_lock is asynchronous to clk; only lock_s_q may feed decisions.
    always_comb begin
        lock_meta_d = bus.pll_lock;
        lock_s_d    = lock_meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_HOLD;
            cnt_q       <= '0;
            retry_q     <= '0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lock_meta_q <= lock_meta_d;
            lock_s_q    <= lock_s_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        if (bus.relock_req) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d = '0;
                        if (retry_q == RETRY_MAX) begin
                            state_d = S_FAIL;
                        end else begin
                            state_d = S_HOLD;
                            retry_d = retry_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_STABLE: begin
                    // A dropout restarts the whole timeout window but keeps the retry count.
                    if (!lock_s_q) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (!lock_s_q) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.pll_rst = 1'b0;
        bus.sys_rst = 1'b1;
        bus.ready   = 1'b0;
        bus.fail    = 1'b0;
        case (state_q)
            S_HOLD: begin
                bus.pll_rst = 1'b1;
            end
            S_RUN: begin
                bus.sys_rst = 1'b0;
                bus.ready   = 1'b1;
            end
            S_FAIL: begin
                bus.pll_rst = 1'b1;
                bus.fail    = 1'b1;
            end
            default: begin
                bus.pll_rst = 1'b0;
            end
        endcase
    end

    assign bus.retry_cnt = retry_q;

`ifdef PLL_LOCK_LOSS_CNT_EN
    logic       loss_evt;
    logic [7:0] loss_cnt_q, loss_cnt_d;

    // relock_req outranks a simultaneous RUN dropout, so that case is not a loss event.
    assign loss_evt = (state_q == S_RUN) && !lock_s_q && !bus.relock_req;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (loss_evt && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign bus.lock_loss_cnt = loss_cnt_q;
`else
    assign bus.lock_loss_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed bench for pll_lock_seq with a phase/elapsed-time reference model checked every cycle.
module tb_pll_lock_seq;
    localparam int HOLD = 4;
    localparam int STAB = 8;
    localparam int TMO  = 32;
    localparam int MAXR = 2;

    localparam int PH_HOLD = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_STAB = 2;
    localparam int PH_RUN  = 3;
    localparam int PH_FAIL = 4;

`ifdef PLL_LOCK_LOSS_CNT_EN
    localparam int LOSS_ON = 1;
`else
    localparam int LOSS_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    pll_lock_seq_if bus ();

    pll_lock_seq #(
        .RST_HOLD_CYCLES    (HOLD),
        .LOCK_STABLE_CYCLES (STAB),
        .LOCK_TIMEOUT_CYCLES(TMO),
        .MAX_RETRY          (MAXR),
        .CNT_W              (17)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase plus cycles elapsed in that phase; lock seen two edges late.
    int       m_ph, m_el, m_retry, m_loss;
    bit [1:0] m_sync;
    bit       m_ls;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph = PH_HOLD; m_el = 0; m_retry = 0; m_loss = 0; m_sync = 2'b00;
        end else begin
            m_ls   = m_sync[1];
            m_sync = {m_sync[0], bus.pll_lock};
            m_el   = m_el + 1;
            if (bus.relock_req) begin
                m_ph = PH_HOLD; m_el = 0; m_retry = 0;
            end else if (m_ph == PH_HOLD) begin
                if (m_el == HOLD) begin m_ph = PH_WAIT; m_el = 0; end
            end else if (m_ph == PH_WAIT) begin
                if (m_ls) begin
                    m_ph = PH_STAB; m_el = 0;
                end else if (m_el == TMO) begin
                    m_el = 0;
                    if (m_retry == MAXR) m_ph = PH_FAIL;
                    else begin m_ph = PH_HOLD; m_retry = m_retry + 1; end
                end
            end else if (m_ph == PH_STAB) begin
                if (!m_ls) begin m_ph = PH_WAIT; m_el = 0; end
                else if (m_el == STAB) begin m_ph = PH_RUN; m_el = 0; m_retry = 0; end
            end else if (m_ph == PH_RUN) begin
                if (!m_ls) begin
                    m_ph = PH_HOLD; m_el = 0;
                    if (LOSS_ON != 0 && m_loss < 255) m_loss = m_loss + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("pll_rst", bus.pll_rst, (m_ph == PH_HOLD || m_ph == PH_FAIL));
        check("sys_rst", bus.sys_rst, (m_ph != PH_RUN));
        check("ready", bus.ready, (m_ph == PH_RUN));
        check("fail", bus.fail, (m_ph == PH_FAIL));
        check("retry_cnt", bus.retry_cnt, m_retry);
        check("lock_loss_cnt", bus.lock_loss_cnt, m_loss);
    end

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.ready;
            1:       return bus.sys_rst;
            default: return bus.fail;
        endcase
    endfunction

    // Counts posedges until the selected output takes val; -1 when the budget runs out.
    task automatic edges_until(input int sel, input logic val, input int maxe, output int n);
        n = 0;
        while (n < maxe) begin
            @(posedge clk);
            n++;
            #1;
            if (sig(sel) === val) return;
        end
        n = -1;
    endtask

    task automatic do_reset(input logic lock_val);
        @(negedge clk);
        rst = 1'b1;
        bus.pll_lock = lock_val;
        bus.relock_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    int n, hi, nev, saved_loss;
    int seen[$];

    initial begin
        bus.pll_lock   = 1'b0;
        bus.relock_req = 1'b0;
        #1 rst = 1'b1;

        // Clean lock
        do_reset(1'b0);
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.pll_rst) hi++;
            @(negedge clk);
        end
        check("t1_pll_rst_cycles", hi, 4);
        repeat (2) @(negedge clk);
        bus.pll_lock = 1'b1;
        edges_until(0, 1'b1, 40, n);
        check("t1_ready_latency", n, 11);
        check("t1_retry", bus.retry_cnt, 0);

        // Lock glitch while qualifying, at stable count 5
        do_reset(1'b1);
        repeat (8) @(negedge clk);
        bus.pll_lock = 1'b0;
        @(negedge clk);
        bus.pll_lock = 1'b1;
        edges_until(0, 1'b1, 40, n);
        check("t2_ready_after_glitch", n, 11);

        // Timeout windows then FAIL
        do_reset(1'b0);
        seen.delete();
        seen.push_back(int'(bus.retry_cnt));
        n = 0;
        while (bus.fail !== 1'b1 && n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (int'(bus.retry_cnt) != seen[$]) seen.push_back(int'(bus.retry_cnt));
        end
        check("t3_edges_to_fail", n, 3 * (HOLD + TMO));
        check("t3_retry_steps", seen.size(), 3);
        check("t3_retry_final", bus.retry_cnt, 2);
        repeat (20) @(negedge clk);
        check("t3_fail_held", bus.fail, 1);
        check("t3_pll_rst_held", bus.pll_rst, 1);
        check("t3_sys_rst_held", bus.sys_rst, 1);
        bus.relock_req = 1'b1;
        @(posedge clk);
        #1;
        check("t3_relock_fail", bus.fail, 0);
        check("t3_relock_retry", bus.retry_cnt, 0);
        check("t3_relock_pll_rst", bus.pll_rst, 1);
        @(negedge clk);
        bus.relock_req = 1'b0;
        bus.pll_lock = 1'b1;
        edges_until(0, 1'b1, 60, n);
        check("t3_relock_to_run", (n > 0), 1);

        // Lock loss in RUN
        check("t4_loss_before", bus.lock_loss_cnt, 0);
        @(negedge clk);
        bus.pll_lock = 1'b0;
        edges_until(1, 1'b1, 10, n);
        check("t4_drop_latency", n, 3);
        check("t4_pll_rst", bus.pll_rst, 1);
        check("t4_loss_after", bus.lock_loss_cnt, LOSS_ON);
        @(negedge clk);
        bus.pll_lock = 1'b1;
        edges_until(0, 1'b1, 60, n);
        check("t4_relock_latency", n, 13);

        // Async reset while qualifying lock
        @(negedge clk);
        bus.pll_lock = 1'b0;
        edges_until(1, 1'b1, 10, n);
        @(negedge clk);
        bus.pll_lock = 1'b1;
        repeat (7) @(posedge clk);
        check("t5_loss_pre_rst", bus.lock_loss_cnt, 2 * LOSS_ON);
        #2 rst = 1'b1;
        #1;
        check("t5_pll_rst", bus.pll_rst, 1);
        check("t5_sys_rst", bus.sys_rst, 1);
        check("t5_ready", bus.ready, 0);
        check("t5_retry", bus.retry_cnt, 0);
        check("t5_loss", bus.lock_loss_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // Repeated lock loss (saturation when the counter is built)
        do_reset(1'b1);
        nev = (LOSS_ON != 0) ? 260 : 3;
        for (int i = 0; i < nev; i++) begin
            edges_until(0, 1'b1, 60, n);
            if (n < 0) begin
                check("t6_reach_run", n, 1);
                break;
            end
            @(negedge clk);
            bus.pll_lock = 1'b0;
            @(negedge clk);
            bus.pll_lock = 1'b1;
        end
        edges_until(0, 1'b1, 60, n);
        check("t6_loss_sat", bus.lock_loss_cnt, (LOSS_ON != 0) ? 255 : 0);

        // relock_req coinciding with a RUN dropout: not counted as a loss
        saved_loss = int'(bus.lock_loss_cnt);
        @(negedge clk);
        bus.pll_lock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.relock_req = 1'b1;
        @(posedge clk);
        #1;
        check("t7_relock_no_loss", bus.lock_loss_cnt, saved_loss);
        check("t7_relock_hold", bus.pll_rst, 1);
        @(negedge clk);
        bus.relock_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
